mul_share_arbiter: RTL

- Controller that shares one 71x4-bit unsigned pipelined multiplier between two requesters.
- The multiplier has 4 clock-enabled register stages, inputs included, and no reset.
- Round-robin arbitration grants one operand pair per cycle into the multiplier.
- A matching tag pipeline tracks validity and requester ID, so each product returns on a single valid/ready output with its ID.
- Output backpressure stalls the whole pipeline by dropping the multiplier clock enable.

---
 rtl/mul_share_arbiter.sv | 85 ++++++++
 1 files changed

// File: rtl/mul_share_arbiter.sv
// Two-requester round-robin front end for a shared pipelined multiplier.
// A tag pipeline tracks validity and requester ID alongside the multiplier stages.
module mul_share_arbiter #(
  parameter int A_WIDTH = 71,
  parameter int B_WIDTH = 4,
  parameter int P_WIDTH = 75,
  parameter int LATENCY = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               req0_valid,
  output logic               req0_ready,
  input  logic [A_WIDTH-1:0] req0_a,
  input  logic [B_WIDTH-1:0] req0_b,
  input  logic               req1_valid,
  output logic               req1_ready,
  input  logic [A_WIDTH-1:0] req1_a,
  input  logic [B_WIDTH-1:0] req1_b,
  output logic               mul_ce,
  output logic [A_WIDTH-1:0] mul_din0,
  output logic [B_WIDTH-1:0] mul_din1,
  input  logic [P_WIDTH-1:0] mul_dout,
  output logic               out_valid,
  input  logic               out_ready,
  output logic               out_id,
  output logic [P_WIDTH-1:0] out_data,
  output logic               busy
);

  logic [LATENCY-1:0] vld;
  logic [LATENCY-1:0] id;
  logic               rr_ptr;
  logic               grant_valid;
  logic               grant_id;

  // Under contention the requester that did not win last time gets the slot.
  always_comb begin
    grant_valid = req0_valid | req1_valid;
    grant_id    = 1'b0;
    if (req0_valid && req1_valid) begin
      grant_id = ~rr_ptr;
    end else if (req1_valid) begin
      grant_id = 1'b1;
    end
  end

  always_comb begin
    mul_din0 = '0;
    mul_din1 = '0;
    if (grant_valid) begin
      if (grant_id) begin
        mul_din0 = req1_a;
        mul_din1 = req1_b;
      end else begin
        mul_din0 = req0_a;
        mul_din1 = req0_b;
      end
    end
  end

  // Outputs are forced quiet while reset is held, even before the tags clear.
  assign out_valid  = reset & vld[LATENCY-1];
  assign out_id     = reset & id[LATENCY-1];
  assign out_data   = mul_dout;
  assign busy       = reset & (|vld);
  assign mul_ce     = reset & ~(out_valid & ~out_ready);
  assign req0_ready = grant_valid & ~grant_id & mul_ce;
  assign req1_ready = grant_valid & grant_id & mul_ce;

  // Tags advance in lockstep with the multiplier; the multiplier itself has no reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      vld    <= '0;
      id     <= '0;
      rr_ptr <= 1'b1;
    end else if (mul_ce) begin
      vld <= {vld[LATENCY-2:0], grant_valid};
      id  <= {id[LATENCY-2:0], grant_valid & grant_id};
      if (grant_valid) begin
        rr_ptr <= grant_id;
      end
    end
  end

endmodule
